// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD nibble width and active-low 7-segment patterns
package bcd_pkg;

  localparam int BCD_W = 4;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_7seg_scan_if.sv
// rtl/bcd_7seg_scan_if.sv - BCD word in, multiplexed display pins out
interface bcd_7seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  import bcd_pkg::*;

  logic [BCD_W*NUM_DIGITS-1:0] bcd_in;
  logic                        load;
  logic                        blank_lz;
  logic [6:0]                  seg;
  logic [NUM_DIGITS-1:0]       an;
  logic                        err;

  modport master (
    output bcd_in, load, blank_lz,
    input  seg, an, err
  );

  modport slave (
    input  bcd_in, load, blank_lz,
    output seg, an, err
  );

endinterface

// File: rtl/bcd_7seg_decode.sv
// rtl/bcd_7seg_decode.sv - combinational nibble to active-low segment decoder
module bcd_7seg_decode
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nibble,
  input  logic             blank,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// rtl/bcd_7seg_scan.sv - latched BCD word driving a time-multiplexed common-anode display
module bcd_7seg_scan
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_7seg_scan_if.slave   bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [BCD_W*NUM_DIGITS-1:0] bcd_reg;
  logic [DIV_W-1:0]            div_cnt;
  logic [IDX_W-1:0]            digit_idx;

  logic [BCD_W-1:0]            nib [NUM_DIGITS];
  logic [IDX_W-1:0]            msd;
  logic                        any_bad;
  logic [BCD_W-1:0]            cur_nib;
  logic                        blank_cur;
  logic [6:0]                  seg_next;
  logic [NUM_DIGITS-1:0]       an_next;
  logic                        wrap;

  // Invalid nibbles count as nonzero so a dash is never blanked away
  always_comb begin
    msd     = '0;
    any_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = bcd_reg[i*BCD_W +: BCD_W];
      if (nib[i] != '0) msd = IDX_W'(i);
      if (nib[i] > 4'd9) any_bad = 1'b1;
    end
  end

  assign cur_nib   = nib[digit_idx];
  assign blank_cur = bus.blank_lz && (digit_idx > msd);
  assign an_next   = ~(NUM_DIGITS'(1) << digit_idx);
  assign wrap      = (div_cnt == DIV_W'(REFRESH_DIV - 1));

  bcd_7seg_decode u_decode (
    .nibble (cur_nib),
    .blank  (blank_cur),
    .seg    (seg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg   <= '0;
      div_cnt   <= '0;
      digit_idx <= '0;
      bus.an    <= '1;
      bus.seg   <= SEG_BLANK;
      bus.err   <= 1'b0;
    end else begin
      if (bus.load) bcd_reg <= bus.bcd_in;
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) begin
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end
      bus.an  <= an_next;
      bus.seg <= seg_next;
      bus.err <= any_bad;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// tb/tb_bcd_7seg_scan.sv - scoreboard bench for bcd_7seg_scan with directed vectors
module tb_bcd_7seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  localparam logic [6:0]  BL      = 7'b1111111;
  localparam logic [27:0] T_ZERO  = {4{7'b1000000}};
  localparam logic [27:0] T_1234  = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] T_0042  = {BL, BL, 7'b0011001, 7'b0100100};
  localparam logic [27:0] T_0000L = {BL, BL, BL, 7'b1000000};
  localparam logic [27:0] T_9A05  = {7'b0010000, 7'b0111111, 7'b1000000, 7'b0010010};
  localparam logic [27:0] T_0905  = {7'b1000000, 7'b0010000, 7'b1000000, 7'b0010010};
  localparam logic [27:0] T_5555  = {4{7'b0010010}};
  localparam logic [27:0] T_8888  = {4{7'b0000000}};

  typedef struct {
    int         stamp;
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   base   = 4;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  bcd_7seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  bcd_7seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Displayed digit at a given output edge follows from the scan start edge
  task automatic push_span(input int from, input int to, input logic [27:0] tab,
                           input logic err_e, input string tag);
    for (int s = from; s <= to; s++) begin
      exp_t e;
      int   d;
      d       = ((s - base) / RD) % ND;
      e.stamp = s;
      e.an    = ~(4'b0001 << d);
      e.seg   = tab[d*7 +: 7];
      e.err   = err_e;
      e.tag   = tag;
      sb.push_back(e);
    end
  endtask

  task automatic push_reset(input int from, input int to, input string tag);
    for (int s = from; s <= to; s++) begin
      exp_t e;
      e.stamp = s;
      e.an    = 4'b1111;
      e.seg   = 7'b1111111;
      e.err   = 1'b0;
      e.tag   = tag;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic load_at(input int edge_n, input logic [15:0] v, input logic blz);
    wait_until(edge_n - 1);
    bus.bcd_in   = v;
    bus.blank_lz = blz;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s cycle %0d: expected output was never sampled", sb[0].tag, sb[0].stamp);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].stamp == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg || bus.err !== e.err) begin
        errors++;
        $display("FAIL %s cycle %0d: got an=%b seg=%b err=%b, expected an=%b seg=%b err=%b",
                 e.tag, cyc, bus.an, bus.seg, bus.err, e.an, e.seg, e.err);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.bcd_in   = '0;
    bus.blank_lz = 1'b0;

    push_reset(1, 3, "reset");
    push_span(4, 19, T_ZERO, 1'b0, "post_reset");
    tick(); tick(); tick();
    rst = 1'b0;

    push_span(20, 51, T_1234, 1'b0, "h1234");
    load_at(19, 16'h1234, 1'b0);

    push_span(52, 67, T_0042, 1'b0, "h0042_lz");
    load_at(51, 16'h0042, 1'b1);

    push_span(68, 82, T_0000L, 1'b0, "h0000_lz");
    load_at(67, 16'h0000, 1'b1);

    push_span(84, 99, T_9A05, 1'b1, "h9A05_err");
    load_at(83, 16'h9A05, 1'b0);

    push_span(100, 115, T_0905, 1'b0, "h0905_noerr");
    load_at(99, 16'h0905, 1'b0);

    push_span(116, 123, T_5555, 1'b0, "h5555");
    push_span(124, 141, T_8888, 1'b0, "h8888_wrap");
    load_at(115, 16'h5555, 1'b0);
    load_at(123, 16'h8888, 1'b0);

    push_reset(142, 142, "rst_mid");
    base = 143;
    push_span(143, 158, T_ZERO, 1'b0, "restart");
    wait_until(141);
    rst        = 1'b1;
    bus.bcd_in = 16'h7777;
    bus.load   = 1'b1;
    tick();
    rst      = 1'b0;
    bus.load = 1'b0;

    for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
